// File: rtl/dsp48a1_slice_if.sv
// Operand/result bundle for the DSP48A1-style slice, including clock enables.
// master drives operands, controls and enables; slave is the slice itself.
// Ports: a/b/d/bcin 18b, c/pcin 48b, carryin, opmode 8b, ce_* in; bcout, m, p, pcout, carryout(f) out.
interface dsp48a1_slice_if;
  logic [17:0] a;
  logic [17:0] b;
  logic [17:0] d;
  logic [17:0] bcin;
  logic [47:0] c;
  logic [47:0] pcin;
  logic        carryin;
  logic [7:0]  opmode;
  logic        ce_a;
  logic        ce_b;
  logic        ce_c;
  logic        ce_d;
  logic        ce_m;
  logic        ce_p;
  logic        ce_carryin;
  logic        ce_opmode;
  logic [17:0] bcout;
  logic [35:0] m;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        carryoutf;

  modport master (
    output a, b, d, bcin, c, pcin, carryin, opmode,
    output ce_a, ce_b, ce_c, ce_d, ce_m, ce_p, ce_carryin, ce_opmode,
    input  bcout, m, p, pcout, carryout, carryoutf
  );

  modport slave (
    input  a, b, d, bcin, c, pcin, carryin, opmode,
    input  ce_a, ce_b, ce_c, ce_d, ce_m, ce_p, ce_carryin, ce_opmode,
    output bcout, m, p, pcout, carryout, carryoutf
  );
endinterface

// File: rtl/dsp48a1_slice.sv
// Spartan-6 DSP48A1-style slice: 18b pre-adder, 18x18 unsigned multiplier, 48b post-adder.
// Ports: clk_i, per-group sync active-high resets rst_*_i, and a dsp48a1_slice_if slave bundle.
// Latency (defaults): BCOUT 2, M 3, P via M 4, P via D:A:B/C/PCIN 3. No backpressure.
// Optional feature macro DSP_BCIN_CASCADE_EN: when defined, B_INPUT="CASCADE" feeds BCIN into B0;
// when undefined BCIN is ignored and B is always taken directly.

// Optional pipeline register: sync reset beats clock enable; EN=0 turns it into a wire.
module dsp48a1_reg #(
  parameter int unsigned W  = 18,
  parameter bit          EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  generate
    if (EN) begin : g_reg
      logic [W-1:0] q_q;
      always_ff @(posedge clk_i) begin
        if (rst_i)     q_q <= '0;
        else if (ce_i) q_q <= d_i;
      end
      assign q_o = q_q;
    end else begin : g_wire
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk_i, rst_i, ce_i};
      assign q_o = d_i;
    end
  endgenerate
endmodule

module dsp48a1_slice #(
  parameter int unsigned A0REG       = 0,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 0,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter string       CARRYINSEL  = "OPMODE5",
  parameter string       B_INPUT     = "DIRECT"
) (
  input logic              clk_i,
  input logic              rst_a_i,
  input logic              rst_b_i,
  input logic              rst_m_i,
  input logic              rst_p_i,
  input logic              rst_c_i,
  input logic              rst_d_i,
  input logic              rst_carryin_i,
  input logic              rst_opmode_i,
  dsp48a1_slice_if.slave   bus
);
  logic [7:0]  op_q;
  logic [17:0] b_src;
  logic [17:0] a0_q, a1_q, b0_q, b1_q, b1_d, d_q, pre_sum;
  logic [47:0] c_q, x_mux, z_mux;
  logic [35:0] m_d, m_q;
  logic        cyi_d, cyi_q;
  logic [48:0] post_d, x_ext, z_ext, cin_ext;
  logic [47:0] p_q;
  logic        cyo_q;

`ifdef DSP_BCIN_CASCADE_EN
  assign b_src = (B_INPUT == "CASCADE") ? bus.bcin : bus.b;
`else
  logic unused_bcin;
  assign unused_bcin = &{1'b0, bus.bcin, (B_INPUT == "CASCADE")};
  assign b_src = bus.b;
`endif

  dsp48a1_reg #(.W(8), .EN(OPMODEREG != 0)) u_opmode (
    .clk_i(clk_i), .rst_i(rst_opmode_i), .ce_i(bus.ce_opmode), .d_i(bus.opmode), .q_o(op_q));

  dsp48a1_reg #(.W(18), .EN(A0REG != 0)) u_a0 (
    .clk_i(clk_i), .rst_i(rst_a_i), .ce_i(bus.ce_a), .d_i(bus.a), .q_o(a0_q));
  dsp48a1_reg #(.W(18), .EN(A1REG != 0)) u_a1 (
    .clk_i(clk_i), .rst_i(rst_a_i), .ce_i(bus.ce_a), .d_i(a0_q), .q_o(a1_q));

  dsp48a1_reg #(.W(18), .EN(B0REG != 0)) u_b0 (
    .clk_i(clk_i), .rst_i(rst_b_i), .ce_i(bus.ce_b), .d_i(b_src), .q_o(b0_q));

  dsp48a1_reg #(.W(18), .EN(DREG != 0)) u_d (
    .clk_i(clk_i), .rst_i(rst_d_i), .ce_i(bus.ce_d), .d_i(bus.d), .q_o(d_q));

  // Pre-adder wraps modulo 2^18; op[6] picks D-B0 over D+B0.
  assign pre_sum = op_q[6] ? (d_q - b0_q) : (d_q + b0_q);
  assign b1_d    = op_q[4] ? pre_sum : b0_q;

  dsp48a1_reg #(.W(18), .EN(B1REG != 0)) u_b1 (
    .clk_i(clk_i), .rst_i(rst_b_i), .ce_i(bus.ce_b), .d_i(b1_d), .q_o(b1_q));

  dsp48a1_reg #(.W(48), .EN(CREG != 0)) u_c (
    .clk_i(clk_i), .rst_i(rst_c_i), .ce_i(bus.ce_c), .d_i(bus.c), .q_o(c_q));

  assign m_d = {18'd0, a1_q} * {18'd0, b1_q};

  dsp48a1_reg #(.W(36), .EN(MREG != 0)) u_m (
    .clk_i(clk_i), .rst_i(rst_m_i), .ce_i(bus.ce_m), .d_i(m_d), .q_o(m_q));

  always_comb begin
    x_mux = '0;
    case (op_q[1:0])
      2'd0:    x_mux = '0;
      2'd1:    x_mux = {12'd0, m_q};
      2'd2:    x_mux = p_q;
      default: x_mux = {d_q[11:0], a1_q, b1_q};
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (op_q[3:2])
      2'd0:    z_mux = '0;
      2'd1:    z_mux = bus.pcin;
      2'd2:    z_mux = p_q;
      default: z_mux = c_q;
    endcase
  end

  assign cyi_d = (CARRYINSEL == "CARRYIN") ? bus.carryin : op_q[5];

  dsp48a1_reg #(.W(1), .EN(CARRYINREG != 0)) u_cyi (
    .clk_i(clk_i), .rst_i(rst_carryin_i), .ce_i(bus.ce_carryin), .d_i(cyi_d), .q_o(cyi_q));

  // 49-bit post-adder: bit 48 is carry on add and borrow on subtract,
  // since X+CIN never exceeds 2^48 the subtract's top bit flags underflow.
  assign x_ext   = {1'b0, x_mux};
  assign z_ext   = {1'b0, z_mux};
  assign cin_ext = {48'd0, cyi_q};
  assign post_d  = op_q[7] ? (z_ext - (x_ext + cin_ext)) : (z_ext + x_ext + cin_ext);

  dsp48a1_reg #(.W(48), .EN(PREG != 0)) u_p (
    .clk_i(clk_i), .rst_i(rst_p_i), .ce_i(bus.ce_p), .d_i(post_d[47:0]), .q_o(p_q));

  dsp48a1_reg #(.W(1), .EN(CARRYOUTREG != 0)) u_cyo (
    .clk_i(clk_i), .rst_i(rst_carryin_i), .ce_i(bus.ce_carryin), .d_i(post_d[48]), .q_o(cyo_q));

  assign bus.bcout     = b1_q;
  assign bus.m         = m_q;
  assign bus.p         = p_q;
  assign bus.pcout     = p_q;
  assign bus.carryout  = cyo_q;
  assign bus.carryoutf = cyo_q;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// Bench for dsp48a1_slice: directed scenarios plus randomized steady-state and P-feedback runs,
// all compared against an arithmetic reference model.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
module tb_dsp48a1_slice;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_m, rst_p, rst_c, rst_d, rst_carryin, rst_opmode;
  int   n_cmp = 0;
  int   n_bad = 0;

  dsp48a1_slice_if dsp_if ();

  dsp48a1_slice dut (
    .clk_i(clk), .rst_a_i(rst_a), .rst_b_i(rst_b), .rst_m_i(rst_m), .rst_p_i(rst_p),
    .rst_c_i(rst_c), .rst_d_i(rst_d), .rst_carryin_i(rst_carryin), .rst_opmode_i(rst_opmode),
    .bus(dsp_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    rst_a = v; rst_b = v; rst_m = v; rst_p = v;
    rst_c = v; rst_d = v; rst_carryin = v; rst_opmode = v;
  endtask

  task automatic set_ce(input logic v);
    dsp_if.ce_a = v; dsp_if.ce_b = v; dsp_if.ce_c = v; dsp_if.ce_d = v;
    dsp_if.ce_m = v; dsp_if.ce_p = v; dsp_if.ce_carryin = v; dsp_if.ce_opmode = v;
  endtask

  task automatic drive(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                       input logic [47:0] c, input logic [17:0] d, input logic [47:0] pcin);
    dsp_if.opmode = op; dsp_if.a = a; dsp_if.b = b; dsp_if.c = c; dsp_if.d = d;
    dsp_if.pcin = pcin; dsp_if.carryin = 1'($urandom); dsp_if.bcin = 18'($urandom);
  endtask

  task automatic check_all(input string tag, input logic [17:0] bc, input logic [35:0] m,
                           input logic [47:0] p, input logic co);
    check({tag, ".bcout"}, 64'(dsp_if.bcout), 64'(bc));
    check({tag, ".m"}, 64'(dsp_if.m), 64'(m));
    check({tag, ".p"}, 64'(dsp_if.p), 64'(p));
    check({tag, ".pcout"}, 64'(dsp_if.pcout), 64'(p));
    check({tag, ".carryout"}, 64'(dsp_if.carryout), 64'(co));
    check({tag, ".carryoutf"}, 64'(dsp_if.carryoutf), 64'(co));
  endtask

  // Reference: what the slice settles to for held inputs, given the previous P.
  // Carry-in is OPMODE[5] in the default configuration.
  function automatic void model(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                                input logic [47:0] c, input logic [17:0] d, input logic [47:0] pcin,
                                input logic [47:0] p_prev, output logic [17:0] bc,
                                output logic [35:0] m, output logic [48:0] res);
    logic [17:0] pre;
    logic [47:0] x, z;
    logic [48:0] cin;
    pre = op[6] ? d - b : d + b;
    bc  = op[4] ? pre : b;
    m   = {18'd0, a} * {18'd0, bc};
    case (op[1:0])
      2'd0: x = 48'd0;
      2'd1: x = {12'd0, m};
      2'd2: x = p_prev;
      default: x = {d[11:0], a, bc};
    endcase
    case (op[3:2])
      2'd0: z = 48'd0;
      2'd1: z = pcin;
      2'd2: z = p_prev;
      default: z = c;
    endcase
    cin = {48'd0, op[5]};
    if (op[7]) res = {1'b0, z} - {1'b0, x} - cin;
    else       res = {1'b0, z} + {1'b0, x} + cin;
  endfunction

  initial begin
    logic [7:0]  op;
    logic [17:0] ra, rb, rd, bc;
    logic [47:0] rc, rp, p_mod;
    logic [35:0] m;
    logic [48:0] res;

    set_rst(1'b1);
    set_ce(1'b1);
    drive(8'h00, 18'd0, 18'd0, 48'd0, 18'd0, 48'd0);

    // 1: all resets asserted, random data and enables -> everything zero.
    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
            18'($urandom), 48'({$urandom, $urandom}));
      set_ce(1'($urandom));
      dsp_if.ce_p = 1'($urandom);
      tick();
      check_all("reset", 18'd0, 36'd0, 48'd0, 1'b0);
    end

    // 2: C - (M + 0) with pre-subtract into B1.
    set_rst(1'b0);
    set_ce(1'b1);
    drive(8'hDD, 18'h14, 18'hA, 48'h15E, 18'h19, 48'd0);
    repeat (4) tick();
    check_all("op_dd", 18'hF, 36'h12C, 48'h32, 1'b0);

    // 3: pre-add into B1, X=Z=0.
    drive(8'h10, 18'h14, 18'hA, 48'h15E, 18'h19, 48'd0);
    repeat (3) tick();
    check_all("op_10", 18'h23, 36'h2BC, 48'h0, 1'b0);

    // 4: P+P feedback from zero stays zero.
    drive(8'h0A, 18'h14, 18'hA, 48'h15E, 18'h19, 48'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) check_all("op_0a", 18'hA, 36'hC8, 48'h0, 1'b0);
    end

    // 5: PCIN - (D:A:B + 1), borrow expected.
    drive(8'hA7, 18'h5, 18'h6, 48'h15E, 18'h19, 48'hBB8);
    repeat (3) tick();
    check_all("op_a7", 18'h6, 36'h1E, 48'hFE6FFFEC0BB1, 1'b1);

    // 6: enables off hold every register; RSTP then clears P alone.
    set_ce(1'b0);
    drive(8'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
          18'($urandom), 48'({$urandom, $urandom}));
    repeat (3) tick();
    check_all("hold", 18'h6, 36'h1E, 48'hFE6FFFEC0BB1, 1'b1);
    rst_p = 1'b1;
    tick();
    check_all("rstp", 18'h6, 36'h1E, 48'h0, 1'b1);
    rst_p = 1'b0;
    set_ce(1'b1);

    // Random held operands with no P feedback: outputs settle to the model.
    for (int i = 0; i < 24; i++) begin
      op = 8'($urandom);
      if (op[1:0] == 2'd2) op[1:0] = 2'd1;
      if (op[3:2] == 2'd2) op[3:2] = 2'd3;
      ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
      rc = 48'({$urandom, $urandom}); rp = 48'({$urandom, $urandom});
      drive(op, ra, rb, rc, rd, rp);
      repeat (6) tick();
      model(op, ra, rb, rc, rd, rp, 48'd0, bc, m, res);
      check_all($sformatf("rand%0d_op%02h", i, op), bc, m, res[47:0], res[48]);
    end

    // Random P-feedback runs: hold P in reset while the rest settles, then step the model.
    for (int i = 0; i < 6; i++) begin
      op = 8'($urandom);
      if (i[0]) op[1:0] = 2'd2;
      else      op[3:2] = 2'd2;
      ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
      rc = 48'({$urandom, $urandom}); rp = 48'({$urandom, $urandom});
      drive(op, ra, rb, rc, rd, rp);
      rst_p = 1'b1;
      repeat (6) tick();
      rst_p = 1'b0;
      p_mod = 48'd0;
      for (int k = 0; k < 6; k++) begin
        tick();
        model(op, ra, rb, rc, rd, rp, p_mod, bc, m, res);
        p_mod = res[47:0];
        check_all($sformatf("acc%0d_%0d_op%02h", i, k, op), bc, m, res[47:0], res[48]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
